irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Receiving end of the interrupt sources (timer pulse, external lines, vector registers) for the monocycle CPU.
- Edge-detects up to NUM_IRQ request lines and latches them as pending.
- Applies per-line masks and a global enable, then picks the highest-priority (lowest index) pending line.
- Presents the line's 10-bit vector to the CPU through a req/ack handshake and tracks one in-service interrupt until return-from-interrupt.

Parameters:
NUM_IRQ, 4, number of request lines; index 0 has the highest priority.
ADDR_W, 10, width of the vector and PC address bus (matches stack/PC width).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
irq_in  input  NUM_IRQ  request lines; a 0->1 transition is one event.
irq_vec  input  NUM_IRQ*ADDR_W  vector table; line i occupies bits [i*ADDR_W +: ADDR_W].
int_en  input  1  global interrupt enable from the CPU control unit.
mask_we  input  1  mask register write enable.
mask_wd  input  NUM_IRQ  mask write data; 1 = line enabled.
int_ack  input  1  CPU has saved the PC and jumped to int_vec (one-cycle pulse).
reti  input  1  CPU executed return-from-interrupt (one-cycle pulse).
int_req  output  1  interrupt request to the CPU.
int_vec  output  ADDR_W  vector of the selected line; valid while int_req=1.
int_id  output  log2(NUM_IRQ) (min 1)  index of the line being requested or serviced.
in_service  output  1  an interrupt handler is active.
pending  output  NUM_IRQ  pending-flag register.

Behaviour:
- Reset (async): irq_prev=0, pending=0, mask=all 1s, state=IDLE, int_req=0, int_vec=0, int_id=0, in_service=0.
- Because irq_prev resets to 0, a line held high across reset creates exactly one event on the first clock after reset.
- Edge detect: each clock, irq_prev<=irq_in. pending[i] sets when irq_in[i]=1 and irq_prev[i]=0.
- Masking: masked lines still latch pending and are delivered once unmasked. mask_we writes mask<=mask_wd on the clock edge.
- eligible = pending & mask. Selection is a fixed priority encoder: the lowest set index wins.
- FSM, 3 states, registered outputs:
  - IDLE: int_req=0, in_service=0. If int_en=1 and eligible!=0 -> REQ; latch int_id=winner and int_vec=irq_vec[winner] on the same edge.
  - REQ: int_req=1. int_id and int_vec are frozen, even if a higher-priority line becomes pending.
    - int_ack=1 -> SERVICE; clear pending[int_id]; in_service=1.
    - Else if int_en=0 -> IDLE; request withdrawn, pending kept.
    - int_ack has priority over int_en=0 in the same cycle.
  - SERVICE: int_req=0, in_service=1, int_id held. No nesting: new events only accumulate in pending.
    - reti=1 -> IDLE; in_service=0.
- Latency: irq_in rises before edge k -> pending set after k -> int_req=1 after edge k+1 (2 cycles), given int_en=1, line unmasked, FSM in IDLE.
- After reti, the next request can appear at the earliest one cycle after returning to IDLE (no back-to-back IDLE bypass).
- Simultaneous new edge on line i and ack clearing pending[i]: set wins, so the new event is preserved.
- int_ack outside REQ and reti outside SERVICE are ignored; no state change.
- Reset mid-operation (REQ or SERVICE): immediate return to IDLE, all pending events discarded.
- irq_in is assumed synchronous to clk; synchronisers live outside this block.

Test Plan:
- Vectors 0x100,0x200,0x300,0x3F0, int_en=1, mask=4'b1111. Pulse irq_in[2] -> int_req=1 two cycles later with int_vec=0x300, int_id=2. Ack -> pending=0, in_service=1. reti -> IDLE.
- irq_in[3] and irq_in[1] rise in the same cycle -> int_vec=0x200 first. After ack+reti, int_req reasserts with int_vec=0x3F0.
- mask=4'b1110, pulse irq_in[0] -> pending=4'b0001, no int_req. Write mask=4'b1111 -> int_req with int_vec=0x100 two cycles later.
- In SERVICE for line 1, pulse irq_in[0] -> no int_req until reti. Then int_req with int_vec=0x100 one cycle after IDLE.
- In REQ, drop int_en without ack -> int_req=0 next cycle, pending bit still set. Re-enable -> request re-presented with the same vector.
- Hold irq_in[1]=1 for 5 cycles -> exactly one pending event. Assert reset while in SERVICE -> all outputs zero immediately, mask=4'b1111.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detected pending flags, masking, fixed priority,
// and req/ack/reti handshake tracking one in-service interrupt.
module irq_controller #(
   parameter  int NUM_IRQ = 4,
   parameter  int ADDR_W  = 10,
   localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_IRQ-1:0]        irq_in,
   input  logic [NUM_IRQ*ADDR_W-1:0] irq_vec,
   input  logic                      int_en,
   input  logic                      mask_we,
   input  logic [NUM_IRQ-1:0]        mask_wd,
   input  logic                      int_ack,
   input  logic                      reti,
   output logic                      int_req,
   output logic [ADDR_W-1:0]         int_vec,
   output logic [ID_W-1:0]           int_id,
   output logic                      in_service,
   output logic [NUM_IRQ-1:0]        pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_IRQ-1:0]  prev_q;
   logic [NUM_IRQ-1:0]  pend_q, pend_d;
   logic [NUM_IRQ-1:0]  mask_q, mask_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [ADDR_W-1:0]   vec_q, vec_d;
   logic                req_q, req_d;
   logic                svc_q, svc_d;

   logic [NUM_IRQ-1:0]  rise;
   logic [NUM_IRQ-1:0]  elig;
   logic [NUM_IRQ-1:0]  clr;
   logic                win_vld;
   logic [ID_W-1:0]     win_id;
   logic [ADDR_W-1:0]   win_vec;

   assign rise = irq_in & ~prev_q;
   assign elig = pend_q & mask_q;

   // Fixed-priority pick: lowest eligible index wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      win_vec = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(i);
            win_vec = irq_vec[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Handshake FSM; a new edge beats the ack clear on the same line.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      vec_d   = vec_q;
      req_d   = 1'b0;
      svc_d   = 1'b0;
      clr     = '0;
      mask_d  = mask_we ? mask_wd : mask_q;
      unique case (state_q)
         IDLE: begin
            if (int_en && win_vld) begin
               state_d = REQ;
               id_d    = win_id;
               vec_d   = win_vec;
               req_d   = 1'b1;
            end
         end
         REQ: begin
            if (int_ack) begin
               state_d     = SERVICE;
               clr[id_q]   = 1'b1;
               svc_d       = 1'b1;
            end else if (!int_en) begin
               state_d = IDLE;
            end else begin
               req_d = 1'b1;
            end
         end
         SERVICE: begin
            if (reti) begin
               state_d = IDLE;
            end else begin
               svc_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      pend_d = (pend_q & ~clr) | rise;
   end

   // State, flags and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         prev_q  <= '0;
         pend_q  <= '0;
         mask_q  <= '1;
         id_q    <= '0;
         vec_q   <= '0;
         req_q   <= 1'b0;
         svc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= irq_in;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         id_q    <= id_d;
         vec_q   <= vec_d;
         req_q   <= req_d;
         svc_q   <= svc_d;
      end
   end

   assign int_req    = req_q;
   assign int_vec    = vec_q;
   assign int_id     = id_q;
   assign in_service = svc_q;
   assign pending    = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller.
// Compares {int_req,int_vec,int_id,in_service,pending} against hand values.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_in;
   logic [39:0] irq_vec;
   logic        int_en;
   logic        mask_we;
   logic [3:0]  mask_wd;
   logic        int_ack;
   logic        reti;
   logic        int_req;
   logic [9:0]  int_vec;
   logic [1:0]  int_id;
   logic        in_service;
   logic [3:0]  pending;

   int errors = 0;
   int checks = 0;

   logic [17:0] obs;
   logic [17:0] exp_v;
   assign obs = {int_req, int_vec, int_id, in_service, pending};

   irq_controller #(.NUM_IRQ(4), .ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .irq_vec(irq_vec),
      .int_en(int_en), .mask_we(mask_we), .mask_wd(mask_wd),
      .int_ack(int_ack), .reti(reti), .int_req(int_req),
      .int_vec(int_vec), .int_id(int_id), .in_service(in_service),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; irq_in = '0; int_en = 1'b1;
      mask_we = 1'b0; mask_wd = '0; int_ack = 1'b0; reti = 1'b0;
      irq_vec = {10'h3F0, 10'h300, 10'h200, 10'h100};
      step(2);
      exp_v = {1'b0, 10'h000, 2'd0, 1'b0, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_state got %h exp %h", obs, exp_v);
      end
      reset = 1'b0;
      step(2);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_idle got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_basic;
      irq_in = 4'b0100;
      step(1);
      irq_in = '0;
      exp_v = {1'b0, 10'h000, 2'd0, 1'b0, 4'b0100};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL basic_pend got %h exp %h", obs, exp_v);
      end
      step(1);
      exp_v = {1'b1, 10'h300, 2'd2, 1'b0, 4'b0100};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL basic_req got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      exp_v = {1'b0, 10'h300, 2'd2, 1'b1, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL basic_ack got %h exp %h", obs, exp_v);
      end
      reti = 1'b1;
      step(1);
      reti = 1'b0;
      exp_v = {1'b0, 10'h300, 2'd2, 1'b0, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL basic_reti got %h exp %h", obs, exp_v);
      end
   endtask

   task automatic test_priority;
      irq_in = 4'b1010;
      step(1);
      irq_in = '0;
      step(1);
      exp_v = {1'b1, 10'h200, 2'd1, 1'b0, 4'b1010};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL prio_first got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      reti = 1'b1;
      step(1);
      reti = 1'b0;
      exp_v = {1'b0, 10'h200, 2'd1, 1'b0, 4'b1000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL prio_idle got %h exp %h", obs, exp_v);
      end
      step(1);
      exp_v = {1'b1, 10'h3F0, 2'd3, 1'b0, 4'b1000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL prio_second got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   task automatic test_mask;
      mask_we = 1'b1; mask_wd = 4'b1110;
      step(1);
      mask_we = 1'b0;
      irq_in = 4'b0001;
      step(1);
      irq_in = '0;
      step(2);
      exp_v = {1'b0, 10'h3F0, 2'd3, 1'b0, 4'b0001};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mask_hold got %h exp %h", obs, exp_v);
      end
      mask_we = 1'b1; mask_wd = 4'b1111;
      step(1);
      mask_we = 1'b0;
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL mask_wr_edge got %b exp 0", int_req);
      end
      step(1);
      exp_v = {1'b1, 10'h100, 2'd0, 1'b0, 4'b0001};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mask_release got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   task automatic test_no_nesting;
      irq_in = 4'b0010;
      step(1);
      irq_in = '0;
      step(1);
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      irq_in = 4'b0001;
      step(1);
      irq_in = '0;
      step(2);
      exp_v = {1'b0, 10'h200, 2'd1, 1'b1, 4'b0001};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL nest_blocked got %h exp %h", obs, exp_v);
      end
      reti = 1'b1;
      step(1);
      reti = 1'b0;
      checks++;
      if ({int_req, in_service} !== 2'b00) begin
         errors++;
         $display("FAIL nest_idle got %b exp 00", {int_req, in_service});
      end
      step(1);
      exp_v = {1'b1, 10'h100, 2'd0, 1'b0, 4'b0001};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL nest_after got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   task automatic test_withdraw;
      irq_in = 4'b1000;
      step(1);
      irq_in = '0;
      step(1);
      int_en = 1'b0;
      step(1);
      exp_v = {1'b0, 10'h3F0, 2'd3, 1'b0, 4'b1000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL withdraw got %h exp %h", obs, exp_v);
      end
      int_en = 1'b1;
      step(1);
      exp_v = {1'b1, 10'h3F0, 2'd3, 1'b0, 4'b1000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL represent got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1; int_en = 1'b0;
      step(1);
      int_ack = 1'b0; int_en = 1'b1;
      exp_v = {1'b0, 10'h3F0, 2'd3, 1'b1, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL ack_over_en got %h exp %h", obs, exp_v);
      end
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   task automatic test_ignored_and_collide;
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      reti = 1'b1;
      step(1);
      reti = 1'b0;
      exp_v = {1'b0, 10'h3F0, 2'd3, 1'b0, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL idle_ignore got %h exp %h", obs, exp_v);
      end
      irq_in = 4'b0100;
      step(1);
      irq_in = '0;
      step(1);
      int_ack = 1'b1; irq_in = 4'b0100;
      step(1);
      int_ack = 1'b0; irq_in = '0;
      exp_v = {1'b0, 10'h300, 2'd2, 1'b1, 4'b0100};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL set_wins got %h exp %h", obs, exp_v);
      end
      reti = 1'b1;
      step(1);
      reti = 1'b0;
      step(1);
      exp_v = {1'b1, 10'h300, 2'd2, 1'b0, 4'b0100};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL set_wins_req got %h exp %h", obs, exp_v);
      end
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      reti = 1'b1;
      step(1);
      reti = 1'b0;
   endtask

   task automatic test_level_and_reset;
      int_en = 1'b0;
      irq_in = 4'b0010;
      step(5);
      irq_in = '0;
      checks++;
      if (pending !== 4'b0010) begin
         errors++;
         $display("FAIL level_once got %b exp 0010", pending);
      end
      int_en = 1'b1;
      step(1);
      int_ack = 1'b1;
      step(1);
      int_ack = 1'b0;
      step(2);
      exp_v = {1'b0, 10'h200, 2'd1, 1'b1, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL level_svc got %h exp %h", obs, exp_v);
      end
      mask_we = 1'b1; mask_wd = 4'b0000;
      step(1);
      mask_we = 1'b0;
      irq_in = 4'b0100;
      step(1);
      reset = 1'b1;
      #1;
      exp_v = {1'b0, 10'h000, 2'd0, 1'b0, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL async_reset got %h exp %h", obs, exp_v);
      end
      step(1);
      reset = 1'b0;
      step(1);
      exp_v = {1'b0, 10'h000, 2'd0, 1'b0, 4'b0100};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL held_edge got %h exp %h", obs, exp_v);
      end
      step(1);
      irq_in = '0;
      exp_v = {1'b1, 10'h300, 2'd2, 1'b0, 4'b0100};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mask_reset got %h exp %h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_no_nesting();
      test_withdraw();
      test_ignored_and_collide();
      test_level_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
